mread_arbiter: RTL and testbench
================================

Name: mread_arbiter

Overview:
- Shares the single-port, one-cycle-latency DPI memory read block (mread) between two requesters: instruction fetch (IFU) and load unit (LSU).
- Each cycle it grants at most one request and drives the granted address onto mread.
- It remembers which requester owns the read in flight and routes the returned data back to that requester one cycle later.
- LSU has priority. A starvation limiter guarantees forward progress for the IFU.

Parameters:
- STARVE_LIMIT, 4: max consecutive LSU grants while the IFU is waiting; the next contested cycle goes to the IFU. Must be at least 1.
- STAT_W, 32: width of the statistics counters (optional feature only).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- ifu_req_valid  in  1  IFU read request.
- ifu_req_addr  in  REG_END_WORD+1  IFU byte address.
- ifu_req_ready  out  1  IFU request granted this cycle.
- ifu_resp_valid  out  1  IFU read data valid.
- ifu_resp_data  out  REG_END_WORD+1  IFU read data.
- lsu_req_valid  in  1  LSU read request.
- lsu_req_addr  in  REG_END_WORD+1  LSU byte address.
- lsu_req_ready  out  1  LSU request granted this cycle.
- lsu_resp_valid  out  1  LSU read data valid.
- lsu_resp_data  out  REG_END_WORD+1  LSU read data.
- mem_addr  out  REG_END_WORD+1  address to mread.addr.
- mem_rdata  in  REG_END_WORD+1  data from mread.rdata; corresponds to the mem_addr of the previous cycle.

Behaviour:
- Handshake:
  - A request transfers in the cycle where valid && ready are both high.
  - Ready is combinational from both valids and the streak register.
  - Requesters must not derive valid from ready.
  - Address must stay stable while valid is high and ready is low.
- Grant rules, per cycle:
  - Only one requester valid: grant it.
  - Both valid and streak < STARVE_LIMIT: grant LSU.
  - Both valid and streak == STARVE_LIMIT: grant IFU.
  - Neither valid: no grant.
- Streak counter:
  - Increments on an LSU grant while IFU valid is high.
  - Clears to 0 on an IFU grant, or on any cycle where IFU valid is low.
  - Saturates at STARVE_LIMIT.
- mem_addr:
  - Combinational: granted requester's address.
  - When no grant, holds the last issued address (registered copy), so mread performs a harmless re-read.
- Owner register (NONE/IFU/LSU):
  - Loaded each cycle with the identity of the current grant, or NONE if there is no grant.
  - This is the only state machine. There are no wait states; throughput is 1 read/cycle.
- Response:
  - x_resp_valid is high in cycle N+1 if and only if owner == x, for a grant in cycle N.
  - x_resp_data = mem_rdata, combinational pass-through.
  - Data is driven on both resp_data outputs; only the valid qualifies it.
  - Responses cannot be back-pressured; requesters must accept.
- Back-to-back grants to different requesters return in grant order, one per cycle.
- Reset:
  - owner=NONE, streak=0, last-address register=0.
  - Both resp_valid outputs low in the cycle after reset.
  - Both ready outputs low while reset is high.
  - A read granted in the cycle before reset asserts is dropped: no resp_valid.
- Addresses are forwarded unmodified. No alignment check; that is the requester's job.

Optional Feature:
- Macro: MREAD_ARB_STATS_EN.
- With the macro defined:
  - Extra output ports stat_ifu_grants, stat_lsu_grants, stat_starve_events, each STAT_W bits.
  - The first two count grants. stat_starve_events counts IFU grants forced by the streak limit.
  - All three clear on reset and wrap on overflow.
- Without the macro: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- REG_END_WORD comes from the shared defs.vh include.
- Add the owner encoding (2-bit enum NONE=0, IFU=1, LSU=2) to the shared package/defs, so trace and debug code can decode it.
- No sub-module; the grant logic is small enough to stay inline.
- Bench instantiates mread_arbiter plus mread, with the DPI mem_read model backing memory.

Test Plan:
- IFU alone requests 0x0, 0x4, 0x8 on consecutive cycles -> ifu_req_ready high each cycle; ifu_resp_valid high in cycles 2..4 with mem words at 0x0, 0x4, 0x8; lsu_resp_valid never high.
- Both valid in one cycle (IFU 0x100, LSU 0x200) -> LSU granted first; lsu_resp_data = word@0x200 next cycle; IFU granted the following cycle once LSU drops valid.
- LSU valid continuously, IFU valid continuously, STARVE_LIMIT=4 -> grant pattern L,L,L,L,I repeating; responses return in the same order.
- Reset asserted in the cycle after an LSU grant -> lsu_resp_valid stays low; after release, the first IFU request at 0x40 returns word@0x40 with correct routing.
- No requests for 3 cycles after a grant at 0x80 -> mem_addr stays 0x80; both resp_valid outputs low throughout.
- With MREAD_ARB_STATS_EN, run the starvation pattern for 10 cycles -> stat_lsu_grants=8, stat_ifu_grants=2, stat_starve_events=2.

Source files
------------

// File: rtl/mread_arbiter_pkg.sv
// Shared definitions for the mread arbiter: data/address word width and the
// in-flight read owner encoding, kept here so trace and debug code can decode it.
package mread_arbiter_pkg;

    // Upper bit index of an address/data word on the mread port.
    localparam int REG_END_WORD = 31;

    // Identity of the requester whose read is in flight.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IFU  = 2'd1,
        OWN_LSU  = 2'd2
    } owner_t;

endpackage

// File: rtl/mread_arbiter.sv
// mread_arbiter: shares the single-port, one-cycle-latency mread block between
// the instruction fetch unit (IFU) and the load/store unit (LSU).
// LSU has priority; a streak limiter forces an IFU grant after STARVE_LIMIT
// consecutive contested LSU grants.
// Optional grant statistics are enabled by defining MREAD_ARB_STATS_EN.
//
// Owner state (one read in flight at most, one read per cycle):
//   state    | meaning
//   OWN_NONE | no read issued last cycle, mem_rdata is ignored
//   OWN_IFU  | last cycle's read belongs to IFU, mem_rdata goes to IFU
//   OWN_LSU  | last cycle's read belongs to LSU, mem_rdata goes to LSU
module mread_arbiter
    import mread_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int STAT_W       = 32
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  ifu_req_valid,
    input  logic [REG_END_WORD:0] ifu_req_addr,
    output logic                  ifu_req_ready,
    output logic                  ifu_resp_valid,
    output logic [REG_END_WORD:0] ifu_resp_data,

    input  logic                  lsu_req_valid,
    input  logic [REG_END_WORD:0] lsu_req_addr,
    output logic                  lsu_req_ready,
    output logic                  lsu_resp_valid,
    output logic [REG_END_WORD:0] lsu_resp_data,

`ifdef MREAD_ARB_STATS_EN
    output logic [STAT_W-1:0]     stat_ifu_grants,
    output logic [STAT_W-1:0]     stat_lsu_grants,
    output logic [STAT_W-1:0]     stat_starve_events,
`endif

    output logic [REG_END_WORD:0] mem_addr,
    input  logic [REG_END_WORD:0] mem_rdata
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    // Reject parameter values that would make the limiter meaningless.
    if (STARVE_LIMIT < 1 || STAT_W < 1) begin : g_bad_param
        $error("mread_arbiter: STARVE_LIMIT and STAT_W must be at least 1");
    end

    owner_t                owner;
    owner_t                owner_next;
    logic [SW-1:0]         streak;
    logic [SW-1:0]         streak_next;
    logic [REG_END_WORD:0] last_addr;

    logic both_valid;
    logic force_ifu;
    logic grant_ifu;
    logic grant_lsu;

    // Grant decision: LSU wins contention unless its streak has hit the limit.
    // Reset suppresses all grants so nothing is issued while reset is high.
    always_comb begin
        both_valid = ifu_req_valid && lsu_req_valid;
        force_ifu  = both_valid && (streak == LIMIT);
        grant_ifu  = 1'b0;
        grant_lsu  = 1'b0;
        if (!reset) begin
            grant_lsu = lsu_req_valid && !force_ifu;
            grant_ifu = ifu_req_valid && (!lsu_req_valid || force_ifu);
        end
    end

    assign ifu_req_ready = grant_ifu;
    assign lsu_req_ready = grant_lsu;

    // Address mux; with no grant, re-issue the last address as a harmless re-read.
    always_comb begin
        mem_addr = last_addr;
        if (grant_ifu) begin
            mem_addr = ifu_req_addr;
        end else if (grant_lsu) begin
            mem_addr = lsu_req_addr;
        end
    end

    // Owner next-state: follows this cycle's grant, NONE when nothing is granted.
    always_comb begin
        owner_next = OWN_NONE;
        if (grant_ifu) begin
            owner_next = OWN_IFU;
        end else if (grant_lsu) begin
            owner_next = OWN_LSU;
        end
    end

    // Streak next value: counts LSU grants taken while IFU is waiting, saturating.
    always_comb begin
        streak_next = streak;
        if (!ifu_req_valid || grant_ifu) begin
            streak_next = '0;
        end else if (grant_lsu && (streak != LIMIT)) begin
            streak_next = streak + SW'(1);
        end
    end

    // Owner state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            owner <= OWN_NONE;
        end else begin
            owner <= owner_next;
        end
    end

    // Streak counter and last-issued address register.
    always_ff @(posedge clock) begin
        if (reset) begin
            streak    <= '0;
            last_addr <= '0;
        end else begin
            streak    <= streak_next;
            last_addr <= mem_addr;
        end
    end

    // Response routing: data is shared, valid follows the owner of last cycle's read.
    // A read granted just before reset is dropped by gating with reset.
    always_comb begin
        ifu_resp_data  = mem_rdata;
        lsu_resp_data  = mem_rdata;
        ifu_resp_valid = !reset && (owner == OWN_IFU);
        lsu_resp_valid = !reset && (owner == OWN_LSU);
    end

`ifdef MREAD_ARB_STATS_EN
    // Grant statistics; free-running, wrap on overflow.
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_ifu_grants    <= '0;
            stat_lsu_grants    <= '0;
            stat_starve_events <= '0;
        end else begin
            if (grant_ifu) begin
                stat_ifu_grants <= stat_ifu_grants + STAT_W'(1);
            end
            if (grant_lsu) begin
                stat_lsu_grants <= stat_lsu_grants + STAT_W'(1);
            end
            if (grant_ifu && force_ifu) begin
                stat_starve_events <= stat_starve_events + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mread_arbiter.sv
// Testbench for mread_arbiter with a behavioural one-cycle-latency memory.
// Define MREAD_ARB_STATS_EN to also exercise the statistics counters.
module tb_mread_arbiter;
    import mread_arbiter_pkg::*;

    typedef struct {
        owner_t      who;
        logic [31:0] data;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        ifu_req_valid, lsu_req_valid;
    logic [31:0] ifu_req_addr, lsu_req_addr;
    logic        ifu_req_ready, lsu_req_ready;
    logic        ifu_resp_valid, lsu_resp_valid;
    logic [31:0] ifu_resp_data, lsu_resp_data;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = 32'h0;
`ifdef MREAD_ARB_STATS_EN
    logic [31:0] stat_ifu_grants, stat_lsu_grants, stat_starve_events;
`endif

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    always #5 clock = ~clock;

    mread_arbiter #(.STARVE_LIMIT(4), .STAT_W(32)) dut (
        .clock              (clock),
        .reset              (reset),
        .ifu_req_valid      (ifu_req_valid),
        .ifu_req_addr       (ifu_req_addr),
        .ifu_req_ready      (ifu_req_ready),
        .ifu_resp_valid     (ifu_resp_valid),
        .ifu_resp_data      (ifu_resp_data),
        .lsu_req_valid      (lsu_req_valid),
        .lsu_req_addr       (lsu_req_addr),
        .lsu_req_ready      (lsu_req_ready),
        .lsu_resp_valid     (lsu_resp_valid),
        .lsu_resp_data      (lsu_resp_data),
`ifdef MREAD_ARB_STATS_EN
        .stat_ifu_grants    (stat_ifu_grants),
        .stat_lsu_grants    (stat_lsu_grants),
        .stat_starve_events (stat_starve_events),
`endif
        .mem_addr           (mem_addr),
        .mem_rdata          (mem_rdata)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // Memory model: data for last cycle's address.
    always @(posedge clock) mem_rdata <= word_at(mem_addr);

    // Scoreboard monitor: compares responses against grants of the previous cycle.
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            total++;
            if (ifu_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0) begin
                bad++;
                $display("FAIL resp_in_reset got ifu=%b lsu=%b want 0 0", ifu_resp_valid, lsu_resp_valid);
            end
            total++;
            if (ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0) begin
                bad++;
                $display("FAIL ready_in_reset got ifu=%b lsu=%b want 0 0", ifu_req_ready, lsu_req_ready);
            end
            sb.delete();
        end else begin
            if (sb.size() != 0) begin
                e = sb.pop_front();
                total++;
                if (ifu_resp_valid !== (e.who == OWN_IFU) || lsu_resp_valid !== (e.who == OWN_LSU)) begin
                    bad++;
                    $display("FAIL resp_route got ifu=%b lsu=%b want owner=%0d", ifu_resp_valid, lsu_resp_valid, e.who);
                end
                total++;
                if ((e.who == OWN_IFU ? ifu_resp_data : lsu_resp_data) !== e.data) begin
                    bad++;
                    $display("FAIL resp_data got=%h want=%h", (e.who == OWN_IFU ? ifu_resp_data : lsu_resp_data), e.data);
                end
            end else if (ifu_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0) begin
                total++;
                bad++;
                $display("FAIL spurious_resp got ifu=%b lsu=%b want 0 0", ifu_resp_valid, lsu_resp_valid);
            end
            if (ifu_req_valid && ifu_req_ready) begin
                sb.push_back('{who: OWN_IFU, data: word_at(ifu_req_addr)});
                total++;
                if (mem_addr !== ifu_req_addr) begin
                    bad++;
                    $display("FAIL mem_addr_ifu got=%h want=%h", mem_addr, ifu_req_addr);
                end
            end
            if (lsu_req_valid && lsu_req_ready) begin
                sb.push_back('{who: OWN_LSU, data: word_at(lsu_req_addr)});
                total++;
                if (mem_addr !== lsu_req_addr) begin
                    bad++;
                    $display("FAIL mem_addr_lsu got=%h want=%h", mem_addr, lsu_req_addr);
                end
            end
            total++;
            if (ifu_req_ready === 1'b1 && lsu_req_ready === 1'b1) begin
                bad++;
                $display("FAIL double_grant got ifu=1 lsu=1 want at most one");
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h10;
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h20;
        cyc();
        @(negedge clock);
        total++;
        if (ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready got ifu=%b lsu=%b want 0 0", ifu_req_ready, lsu_req_ready);
        end
        cyc();
        reset = 1'b0;
        idle();
        @(negedge clock);
        total++;
        if (ifu_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_resp got ifu=%b lsu=%b want 0 0", ifu_resp_valid, lsu_resp_valid);
        end
        total++;
        if (mem_addr !== 32'h0) begin
            bad++;
            $display("FAIL post_reset_mem_addr got=%h want=0", mem_addr);
        end
        cyc();
    endtask

    task automatic test_ifu_only();
        for (int i = 0; i < 3; i++) begin
            ifu_req_valid = 1'b1;
            ifu_req_addr  = 32'(i * 4);
            @(negedge clock);
            total++;
            if (ifu_req_ready !== 1'b1 || lsu_req_ready !== 1'b0) begin
                bad++;
                $display("FAIL ifu_only_grant got ifu=%b lsu=%b want 1 0", ifu_req_ready, lsu_req_ready);
            end
            cyc();
        end
        idle();
        cyc();
        cyc();
    endtask

    task automatic test_contention();
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h100;
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h200;
        @(negedge clock);
        total++;
        if (lsu_req_ready !== 1'b1 || ifu_req_ready !== 1'b0) begin
            bad++;
            $display("FAIL contend_first got ifu=%b lsu=%b want 0 1", ifu_req_ready, lsu_req_ready);
        end
        cyc();
        lsu_req_valid = 1'b0;
        @(negedge clock);
        total++;
        if (ifu_req_ready !== 1'b1) begin
            bad++;
            $display("FAIL contend_second got ifu=%b want 1", ifu_req_ready);
        end
        cyc();
        idle();
        cyc();
        cyc();
    endtask

    task automatic test_starvation();
        logic [31:0] ia = 32'h1000;
        logic [31:0] la = 32'h2000;
        logic        exp_ifu;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            ifu_req_valid = 1'b1; ifu_req_addr = ia;
            lsu_req_valid = 1'b1; lsu_req_addr = la;
            exp_ifu = ((c % 5) == 4);
            @(negedge clock);
            total++;
            if (ifu_req_ready !== exp_ifu || lsu_req_ready !== !exp_ifu) begin
                bad++;
                $display("FAIL starve_pattern c=%0d got ifu=%b lsu=%b want ifu=%b", c, ifu_req_ready, lsu_req_ready, exp_ifu);
            end
            if (exp_ifu) ia += 32'h4;
            else         la += 32'h4;
            cyc();
        end
        idle();
`ifdef MREAD_ARB_STATS_EN
        @(negedge clock);
        total++;
        if (stat_lsu_grants !== 32'd8 || stat_ifu_grants !== 32'd2 || stat_starve_events !== 32'd2) begin
            bad++;
            $display("FAIL stats got lsu=%0d ifu=%0d starve=%0d want 8 2 2", stat_lsu_grants, stat_ifu_grants, stat_starve_events);
        end
`endif
        cyc();
        cyc();
    endtask

    task automatic test_reset_drop();
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h300;
        @(negedge clock);
        total++;
        if (lsu_req_ready !== 1'b1) begin
            bad++;
            $display("FAIL drop_grant got lsu=%b want 1", lsu_req_ready);
        end
        cyc();
        idle();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h40;
        @(negedge clock);
        total++;
        if (ifu_req_ready !== 1'b1) begin
            bad++;
            $display("FAIL after_reset_grant got ifu=%b want 1", ifu_req_ready);
        end
        cyc();
        idle();
        cyc();
        cyc();
    endtask

    task automatic test_idle_hold();
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h80;
        cyc();
        idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            total++;
            if (mem_addr !== 32'h80) begin
                bad++;
                $display("FAIL idle_hold i=%0d got=%h want=80", i, mem_addr);
            end
            if (i > 0) begin
                total++;
                if (ifu_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL idle_resp i=%0d got ifu=%b lsu=%b want 0 0", i, ifu_resp_valid, lsu_resp_valid);
                end
            end
            cyc();
        end
    endtask

    task automatic test_drain();
        idle();
        for (int i = 0; i < 4 && sb.size() != 0; i++) cyc();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain got pending=%0d want 0", sb.size());
        end
    endtask

    initial begin
        reset = 1'b1;
        ifu_req_valid = 1'b0; ifu_req_addr = 32'h0;
        lsu_req_valid = 1'b0; lsu_req_addr = 32'h0;
        test_reset();
        test_ifu_only();
        test_contention();
        test_starvation();
        test_reset_drop();
        test_idle_hold();
        test_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
